// File: rtl/fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arb
// Function : Two-requester round-robin write arbiter in front of a FIFO.
//            Bounded bursts per owner, occupancy-aware write issue and a
//            single registered write strobe toward the FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic [DATA_WIDTH-1:0] din0,
    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] din1,
    output logic                  gnt0,
    output logic                  gnt1,
    input  logic [3:0]            fifo_data_count,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_din,
    output logic [1:0]            owner
);

    localparam logic [1:0] c_IDLE       = 2'b00;
    localparam logic [1:0] c_OWN0       = 2'b01;
    localparam logic [1:0] c_OWN1       = 2'b10;
    localparam logic [4:0] c_DEPTH      = 5'(DEPTH);
    localparam logic [3:0] c_BURST_LAST = 4'(MAX_BURST - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [3:0]            r_burst_cnt;
    logic [3:0]            w_burst_nxt;
    logic                  r_last_owner;
    logic                  w_last_nxt;
    logic                  r_fifo_wr_en;
    logic [DATA_WIDTH-1:0] r_fifo_din;
    logic [4:0]            w_occupancy;
    logic                  w_can_accept;
    logic                  w_gnt0;
    logic                  w_gnt1;

    // A write already in flight is counted as occupied; reads are not credited early
    assign w_occupancy  = {1'b0, fifo_data_count} + {4'd0, r_fifo_wr_en};
    assign w_can_accept = (w_occupancy < c_DEPTH);

    // Arbiter state, burst counter and round-robin history
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_burst_cnt  <= 4'd0;
            r_last_owner <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_burst_cnt  <= w_burst_nxt;
            r_last_owner <= w_last_nxt;
        end
    end

    // Next-state: ownership changes on request drop or on burst limit with contention
    always_comb begin
        w_state_nxt = r_state;
        w_burst_nxt = r_burst_cnt;
        w_last_nxt  = r_last_owner;
        case (r_state)
            c_IDLE: begin
                if (req0 && req1) begin
                    w_state_nxt = r_last_owner ? c_OWN0 : c_OWN1;
                end else if (req0) begin
                    w_state_nxt = c_OWN0;
                end else if (req1) begin
                    w_state_nxt = c_OWN1;
                end
            end
            c_OWN0: begin
                if (!req0) begin
                    w_state_nxt = req1 ? c_OWN1 : c_IDLE;
                    w_last_nxt  = 1'b0;
                    w_burst_nxt = 4'd0;
                end else if (w_gnt0) begin
                    if (r_burst_cnt == c_BURST_LAST) begin
                        w_burst_nxt = 4'd0;
                        if (req1) begin
                            w_state_nxt = c_OWN1;
                            w_last_nxt  = 1'b0;
                        end
                    end else begin
                        w_burst_nxt = r_burst_cnt + 4'd1;
                    end
                end
            end
            c_OWN1: begin
                if (!req1) begin
                    w_state_nxt = req0 ? c_OWN0 : c_IDLE;
                    w_last_nxt  = 1'b1;
                    w_burst_nxt = 4'd0;
                end else if (w_gnt1) begin
                    if (r_burst_cnt == c_BURST_LAST) begin
                        w_burst_nxt = 4'd0;
                        if (req0) begin
                            w_state_nxt = c_OWN0;
                            w_last_nxt  = 1'b1;
                        end
                    end else begin
                        w_burst_nxt = r_burst_cnt + 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_burst_nxt = 4'd0;
            end
        endcase
    end

    // Grants: only the current owner, only while the FIFO has room for another word
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (w_can_accept) begin
            w_gnt0 = (r_state == c_OWN0) && req0;
            w_gnt1 = (r_state == c_OWN1) && req1;
        end
    end

    // Register the accepted word toward the FIFO; data holds when idle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fifo_wr_en <= 1'b0;
            r_fifo_din   <= '0;
        end else if (w_gnt0) begin
            r_fifo_wr_en <= 1'b1;
            r_fifo_din   <= din0;
        end else if (w_gnt1) begin
            r_fifo_wr_en <= 1'b1;
            r_fifo_din   <= din1;
        end else begin
            r_fifo_wr_en <= 1'b0;
        end
    end

    assign gnt0       = w_gnt0;
    assign gnt1       = w_gnt1;
    assign fifo_wr_en = r_fifo_wr_en;
    assign fifo_din   = r_fifo_din;
    assign owner      = r_state;

endmodule
`default_nettype wire
